// File: rtl/bram_pkg.sv
// Shared definitions for the byte-enabled dual-port block RAM.
// Byte-lane sizing helpers and the byte-merge used by both the write path
// and the optional same-address read bypass (BRAM_DUAL_BYPASS_EN).
package bram_pkg;

  localparam int BYTE_W = 8;
  localparam int DEFAULT_XLEN = 32;

  // Number of byte lanes in a word of xlen bits.
  function automatic int bytes_f(input int xlen);
    return xlen / BYTE_W;
  endfunction

  localparam int DEFAULT_STRB_W = bytes_f(DEFAULT_XLEN);

  // One byte lane of a strobed merge: take the new byte when its strobe is
  // set, otherwise keep the old byte.
  function automatic logic [BYTE_W-1:0] merge_f(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              strb
  );
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bram_out_stage.sv
// Optional output register for the block RAM read path.
// The data register only loads when a valid result arrives, so the
// output holds the last read result between pulses.
module bram_out_stage
  import bram_pkg::*;
#(
  parameter int W = DEFAULT_XLEN
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  // Second read stage: valid follows the upstream stage, data captured on valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/bram_dual_be_pipe.sv
// Simple-dual-port inferred block RAM with per-byte write strobes and a
// read-valid pipeline; OUT_REG_p selects read latency 1 or 2.
// Optional macro BRAM_DUAL_BYPASS_EN: same-edge read/write to the same
// address returns the byte-merged new word instead of the old word.
//
// Read interface: read_i is always accepted (no ready). rvalid_o pulses for
// exactly one cycle per accepted read, in issue order, at fixed latency;
// data_o holds the last delivered result while rvalid_o is low.
module bram_dual_be_pipe
  import bram_pkg::*;
#(
  parameter int memSize_p = 6,
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int OUT_REG_p = 0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     write_i,
  input  logic [bytes_f(XLEN)-1:0] wstrb_i,
  input  logic [memSize_p-1:0]     waddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic                     read_i,
  input  logic [memSize_p-1:0]     raddr_i,
  output logic [XLEN-1:0]          data_o,
  output logic                     rvalid_o
);

  localparam int STRB_W = bytes_f(XLEN);
  localparam int DEPTH  = 1 << memSize_p;

  if ((XLEN % BYTE_W) != 0) begin : g_bad_xlen
    $error("bram_dual_be_pipe: XLEN must be a multiple of 8");
  end
  if ((OUT_REG_p != 0) && (OUT_REG_p != 1)) begin : g_bad_out_reg
    $error("bram_dual_be_pipe: OUT_REG_p must be 0 or 1");
  end

  // Storage array; never reset so it maps onto block RAM.
  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic [XLEN-1:0] wr_merged;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] s1_data;
  logic            s1_valid;

  // Write path: merge strobed bytes of data_i into the addressed word.
  always_comb begin
    wr_merged = '0;
    for (int k = 0; k < STRB_W; k++) begin
      wr_merged[k*BYTE_W +: BYTE_W] = merge_f(mem[waddr_i][k*BYTE_W +: BYTE_W],
                                              data_i[k*BYTE_W +: BYTE_W],
                                              wstrb_i[k]);
    end
  end

  // Array write; ignored while reset is held.
  always_ff @(posedge clk_i) begin
    if (write_i && rstn_i) begin
      mem[waddr_i] <= wr_merged;
    end
  end

`ifdef BRAM_DUAL_BYPASS_EN
  logic bypass_hit;

  // Read word with same-address write-through: strobed bytes come from data_i.
  always_comb begin
    bypass_hit = write_i && read_i && rstn_i && (raddr_i == waddr_i);
    rd_word    = '0;
    for (int k = 0; k < STRB_W; k++) begin
      rd_word[k*BYTE_W +: BYTE_W] = merge_f(mem[raddr_i][k*BYTE_W +: BYTE_W],
                                            data_i[k*BYTE_W +: BYTE_W],
                                            wstrb_i[k] && bypass_hit);
    end
  end
`else
  // Read word: plain array read, old data on a same-edge write.
  always_comb begin
    rd_word = mem[raddr_i];
  end
`endif

  // Read stage 1: capture the array word on a read, flag it valid for one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= read_i;
      if (read_i) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUT_REG_p == 1) begin : g_out_reg
    bram_out_stage #(.W(XLEN)) u_out_stage (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (s1_valid),
      .data_i  (s1_data),
      .valid_o (rvalid_o),
      .data_o  (data_o)
    );
  end else begin : g_no_out_reg
    assign data_o   = s1_data;
    assign rvalid_o = s1_valid;
  end

endmodule

// File: tb/tb_bram_dual_be_pipe.sv
// Self-checking bench for bram_dual_be_pipe: one instance at read latency 1
// and one at latency 2 share the same stimulus. A word-array memory model
// and per-instance expected queues (data plus due cycle) predict outputs.
module tb_bram_dual_be_pipe;

  localparam int AW    = 6;
  localparam int W     = 32;
  localparam int SW    = W / 8;
  localparam int DEPTH = 1 << AW;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic          write;
  logic [SW-1:0] wstrb;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          read;
  logic [AW-1:0] raddr;
  logic [W-1:0]  data_l1, data_l2;
  logic          rvalid_l1, rvalid_l2;

  bram_dual_be_pipe #(.memSize_p(AW), .XLEN(W), .OUT_REG_p(0)) dut_l1 (
    .clk_i(clk), .rstn_i(rstn), .write_i(write), .wstrb_i(wstrb), .waddr_i(waddr),
    .data_i(wdata), .read_i(read), .raddr_i(raddr), .data_o(data_l1), .rvalid_o(rvalid_l1)
  );

  bram_dual_be_pipe #(.memSize_p(AW), .XLEN(W), .OUT_REG_p(1)) dut_l2 (
    .clk_i(clk), .rstn_i(rstn), .write_i(write), .wstrb_i(wstrb), .waddr_i(waddr),
    .data_i(wdata), .read_i(read), .raddr_i(raddr), .data_o(data_l2), .rvalid_o(rvalid_l2)
  );

  // Reference model and scoreboard
  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int           due_q1[$];
  int           due_q2[$];
  logic [W-1:0] last1, last2;
  int           cyc;
  int           n_checks;
  int           n_fail;

  function automatic logic [W-1:0] byte_write(input logic [W-1:0] old_w,
                                              input logic [W-1:0] new_w,
                                              input logic [SW-1:0] strb);
    logic [W-1:0] r;
    r = old_w;
    for (int k = 0; k < SW; k++) if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic model_clear();
    exp_q1.delete(); exp_q2.delete(); due_q1.delete(); due_q2.delete();
    last1 = '0; last2 = '0;
  endtask

  // Driver: apply one cycle of inputs from a falling edge, update the model at
  // the rising edge, then compare both instances against the queues.
  task automatic tick(input logic wr, input logic [SW-1:0] st, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input logic rd, input logic [AW-1:0] ra);
    logic [W-1:0] rword;
    logic         ev1, ev2;
    write = wr; wstrb = st; waddr = wa; wdata = wd; read = rd; raddr = ra;
    @(posedge clk);
    cyc++;
    if (rstn) begin
      if (rd) begin
        rword = model_mem[ra];
`ifdef BRAM_DUAL_BYPASS_EN
        if (wr && (wa == ra)) rword = byte_write(rword, wd, st);
`endif
        exp_q1.push_back(rword); due_q1.push_back(cyc);
        exp_q2.push_back(rword); due_q2.push_back(cyc + 1);
      end
      if (wr) model_mem[wa] = byte_write(model_mem[wa], wd, st);
    end
    @(negedge clk);
    ev1 = 1'b0;
    if (due_q1.size() > 0 && due_q1[0] == cyc) begin
      ev1 = 1'b1; last1 = exp_q1.pop_front(); void'(due_q1.pop_front());
    end
    ev2 = 1'b0;
    if (due_q2.size() > 0 && due_q2[0] == cyc) begin
      ev2 = 1'b1; last2 = exp_q2.pop_front(); void'(due_q2.pop_front());
    end
    n_checks += 4;
    if (rvalid_l1 !== ev1) begin n_fail++; $display("FAIL sb_rvalid_l1 cyc=%0d: got %b expected %b", cyc, rvalid_l1, ev1); end
    if (data_l1 !== last1) begin n_fail++; $display("FAIL sb_data_l1 cyc=%0d: got %h expected %h", cyc, data_l1, last1); end
    if (rvalid_l2 !== ev2) begin n_fail++; $display("FAIL sb_rvalid_l2 cyc=%0d: got %b expected %b", cyc, rvalid_l2, ev2); end
    if (data_l2 !== last2) begin n_fail++; $display("FAIL sb_data_l2 cyc=%0d: got %h expected %h", cyc, data_l2, last2); end
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    write = 1'b0; wstrb = '0; waddr = '0; wdata = '0; read = 1'b0; raddr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (data_l1 !== 32'h0)  begin n_fail++; $display("FAIL reset_data_l1: got %h expected 0", data_l1); end
    if (rvalid_l1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_l1: got %b expected 0", rvalid_l1); end
    if (data_l2 !== 32'h0)  begin n_fail++; $display("FAIL reset_data_l2: got %h expected 0", data_l2); end
    if (rvalid_l2 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_l2: got %b expected 0", rvalid_l2); end
    rstn = 1'b1;
    // Give every word a known value so the model is fully defined.
    for (int a = 0; a < DEPTH; a++) tick(1'b1, '1, AW'(a), $urandom, 1'b0, '0);
  endtask

  task automatic test_basic();
    tick(1'b1, 4'hF, 6'h05, 32'hDEADBEEF, 1'b0, '0);
    tick(1'b0, '0, '0, '0, 1'b1, 6'h05);
    n_checks += 2;
    if (data_l1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data_l1: got %h expected deadbeef", data_l1); end
    if (rvalid_l1 !== 1'b1) begin n_fail++; $display("FAIL basic_rvalid_l1: got %b expected 1", rvalid_l1); end
    idle();
    n_checks += 4;
    if (rvalid_l1 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_l1: got %b expected 0", rvalid_l1); end
    if (data_l1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_hold_l1: got %h expected deadbeef", data_l1); end
    if (data_l2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data_l2: got %h expected deadbeef", data_l2); end
    if (rvalid_l2 !== 1'b1) begin n_fail++; $display("FAIL basic_rvalid_l2: got %b expected 1", rvalid_l2); end
    idle();
    n_checks++;
    if (rvalid_l2 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_l2: got %b expected 0", rvalid_l2); end
  endtask

  task automatic test_strobes();
    tick(1'b1, 4'h5, 6'h05, 32'h11223344, 1'b0, '0);
    tick(1'b0, '0, '0, '0, 1'b1, 6'h05);
    n_checks++;
    if (data_l1 !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_data_l1: got %h expected de22be44", data_l1); end
    idle();
    n_checks++;
    if (data_l2 !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_data_l2: got %h expected de22be44", data_l2); end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 4'hF, 6'h00, 32'hA, 1'b0, '0);
    tick(1'b1, 4'hF, 6'h01, 32'hB, 1'b0, '0);
    tick(1'b1, 4'hF, 6'h02, 32'hC, 1'b0, '0);
    tick(1'b0, '0, '0, '0, 1'b1, 6'h00);
    n_checks++;
    if (rvalid_l2 !== 1'b0) begin n_fail++; $display("FAIL b2b_early_l2: got %b expected 0", rvalid_l2); end
    tick(1'b0, '0, '0, '0, 1'b1, 6'h01);
    n_checks += 2;
    if (data_l2 !== 32'hA || rvalid_l2 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_l2: got %h/%b expected a/1", data_l2, rvalid_l2); end
    if (data_l1 !== 32'hB || rvalid_l1 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_l1: got %h/%b expected b/1", data_l1, rvalid_l1); end
    tick(1'b0, '0, '0, '0, 1'b1, 6'h02);
    n_checks++;
    if (data_l2 !== 32'hB || rvalid_l2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_l2: got %h/%b expected b/1", data_l2, rvalid_l2); end
    idle();
    n_checks += 2;
    if (data_l2 !== 32'hC || rvalid_l2 !== 1'b1) begin n_fail++; $display("FAIL b2b_third_l2: got %h/%b expected c/1", data_l2, rvalid_l2); end
    if (rvalid_l1 !== 1'b0) begin n_fail++; $display("FAIL b2b_end_l1: got %b expected 0", rvalid_l1); end
    idle();
    n_checks++;
    if (rvalid_l2 !== 1'b0) begin n_fail++; $display("FAIL b2b_end_l2: got %b expected 0", rvalid_l2); end
  endtask

  task automatic test_read_during_write();
    logic [W-1:0] exp_full, exp_half;
`ifdef BRAM_DUAL_BYPASS_EN
    exp_full = 32'h12345678; exp_half = 32'h00005678;
`else
    exp_full = 32'h0; exp_half = 32'h0;
`endif
    tick(1'b1, 4'hF, 6'h3F, 32'h0, 1'b0, '0);
    tick(1'b1, 4'hF, 6'h3F, 32'h12345678, 1'b1, 6'h3F);
    n_checks++;
    if (data_l1 !== exp_full) begin n_fail++; $display("FAIL rdw_full_l1: got %h expected %h", data_l1, exp_full); end
    idle();
    n_checks++;
    if (data_l2 !== exp_full) begin n_fail++; $display("FAIL rdw_full_l2: got %h expected %h", data_l2, exp_full); end
    tick(1'b1, 4'hF, 6'h3F, 32'h0, 1'b0, '0);
    tick(1'b1, 4'h3, 6'h3F, 32'h12345678, 1'b1, 6'h3F);
    n_checks++;
    if (data_l1 !== exp_half) begin n_fail++; $display("FAIL rdw_half_l1: got %h expected %h", data_l1, exp_half); end
    tick(1'b0, '0, '0, '0, 1'b1, 6'h3F);
    n_checks++;
    if (data_l1 !== 32'h00005678) begin n_fail++; $display("FAIL rdw_after_l1: got %h expected 00005678", data_l1); end
    // Different addresses on the same edge do not interact.
    tick(1'b1, 4'hF, 6'h21, 32'h600DF00D, 1'b0, '0);
    tick(1'b1, 4'hF, 6'h20, 32'hAAAA5555, 1'b1, 6'h21);
    n_checks++;
    if (data_l1 !== 32'h600DF00D) begin n_fail++; $display("FAIL rdw_diff_l1: got %h expected 600df00d", data_l1); end
    idle();
  endtask

  task automatic test_reset_mid_read();
    tick(1'b1, 4'hF, 6'h07, 32'h0BADC0DE, 1'b0, '0);
    tick(1'b0, '0, '0, '0, 1'b1, 6'h07);
    #2 rstn = 1'b0;
    #1;
    model_clear();
    n_checks += 4;
    if (data_l1 !== 32'h0)  begin n_fail++; $display("FAIL midrst_data_l1: got %h expected 0", data_l1); end
    if (rvalid_l1 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_l1: got %b expected 0", rvalid_l1); end
    if (data_l2 !== 32'h0)  begin n_fail++; $display("FAIL midrst_data_l2: got %h expected 0", data_l2); end
    if (rvalid_l2 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_l2: got %b expected 0", rvalid_l2); end
    @(negedge clk);
    tick(1'b1, 4'hF, 6'h07, 32'hFFFFFFFF, 1'b1, 6'h07);
    idle();
    rstn = 1'b1;
    idle();
    idle();
    tick(1'b0, '0, '0, '0, 1'b1, 6'h07);
    idle();
    n_checks++;
    if (data_l2 !== 32'h0BADC0DE) begin n_fail++; $display("FAIL midrst_word_l2: got %h expected 0badc0de", data_l2); end
  endtask

  task automatic test_zero_strobe();
    tick(1'b1, 4'hF, 6'h10, 32'hCAFEF00D, 1'b0, '0);
    tick(1'b1, 4'h0, 6'h10, 32'hFFFFFFFF, 1'b0, '0);
    tick(1'b0, '0, '0, '0, 1'b1, 6'h10);
    n_checks++;
    if (data_l1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL zero_strobe_l1: got %h expected cafef00d", data_l1); end
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] wa, ra;
    for (int i = 0; i < 400; i++) begin
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      tick(1'($urandom_range(0, 1)), SW'($urandom_range(0, 15)), wa, $urandom,
           1'($urandom_range(0, 1)), ra);
    end
    idle();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_basic();
    test_strobes();
    test_back_to_back();
    test_read_during_write();
    test_reset_mid_read();
    test_zero_strobe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_dual_be_pipe.md
Name: bram_dual_be_pipe

Overview:
- Parametrised simple-dual-port inferred block RAM: one write port, one read port, one clock.
- Adds per-byte write strobes, a read-valid flag, and a selectable extra output register stage for timing closure.
- Asynchronous active-low reset clears the read pipeline only, never the array.
- Used as the next-generation backing store for register files, caches and FIFOs in the core.

Parameters:
memSize_p, 6, address width; depth = 2**memSize_p words
XLEN, 32, word width in bits; must be a multiple of 8
OUT_REG_p, 0, 0 = read latency 1; 1 = extra output register, read latency 2

Ports:
clk_i  in  1  clock; all state changes on rising edge
rstn_i  in  1  asynchronous active-low reset
write_i  in  1  write request
wstrb_i  in  XLEN/8  byte write strobes; bit k enables data_i[8k+7:8k]
waddr_i  in  memSize_p  write address
data_i  in  XLEN  write data
read_i  in  1  read request
raddr_i  in  memSize_p  read address
data_o  out  XLEN  read data, held until the next completed read
rvalid_o  out  1  one-cycle pulse when data_o carries a new read result

Behaviour:
- Reset (rstn_i low, asynchronous): data_o = 0, rvalid_o = 0, all internal read-stage registers and valid bits = 0. Memory contents are undefined at power-up and are not cleared.
- Writes while rstn_i low are ignored.
- Reads in flight when reset asserts are discarded; no rvalid_o pulse follows after release.
- Write: at a rising edge with rstn_i high and write_i = 1, each byte k with wstrb_i[k] = 1 is updated; other bytes keep their values.
  - write_i = 1 with wstrb_i = 0 is a no-op.
- Read stage 1: at a rising edge with read_i = 1, s1_data <= memory[raddr_i] and s1_valid <= 1; otherwise s1_valid <= 0 and s1_data holds.
- OUT_REG_p = 0: data_o = s1_data, rvalid_o = s1_valid. Latency is 1 cycle from the read_i edge.
- OUT_REG_p = 1: s2_data <= s1_data when s1_valid = 1; s2_valid <= s1_valid; data_o = s2_data, rvalid_o = s2_valid. Latency is 2 cycles.
- Back-to-back reads: one read accepted per cycle; results emerge in order, one per cycle; rvalid_o stays high continuously.
- data_o holds its last value while rvalid_o = 0.
- Read-during-write, same address, same edge (default build): read returns the OLD word (no write-through).
- Read-during-write, different addresses: independent; no interaction.
- Address wrap: no wrap logic. Addresses are full-width and every value is legal.
- XLEN not a multiple of 8, or OUT_REG_p not 0 or 1: elaboration-time error.

Optional Feature:
- Macro: BRAM_DUAL_BYPASS_EN
- Defined: on a same-edge read/write to the same address, s1_data takes data_i bytes where wstrb_i = 1 and old memory bytes elsewhere (byte-merged write-through).
  - Bypass mux compares raddr_i == waddr_i and write_i & read_i & rstn_i.
- Undefined: old-data semantics as above; no comparator or mux is synthesised.

Decomposition:
- Shared package bram_pkg: function bytes_f(XLEN) = XLEN/8; strobe-width localparam; byte-merge function merge_f(old, new, strb) used by the write path and the bypass path.
- One sub-module, bram_out_stage: a data/valid register pair with async active-low reset, instantiated under a generate on OUT_REG_p.
- Stage 1 stays inline so the array read infers BRAM.

Test Plan:
- Reset release, then OUT_REG_p = 0: write 0xDEADBEEF @0x05 with wstrb = 0xF; next cycle read @0x05 -> one cycle later data_o = 0xDEADBEEF, rvalid_o = 1 for exactly one cycle.
- Byte strobes: @0x05 = 0xDEADBEEF, write 0x11223344 with wstrb = 0x5, then read @0x05 -> data_o = 0xDE22BE44.
- OUT_REG_p = 1: reads @0,1,2 on consecutive cycles (contents 0xA, 0xB, 0xC) -> data_o = 0xA, 0xB, 0xC on cycles 2, 3, 4 after the first read; rvalid_o high for those 3 cycles only.
- Same-edge write 0x12345678 and read @0x3F, old value 0x0, wstrb = 0xF -> default build data_o = 0x0; with BRAM_DUAL_BYPASS_EN, data_o = 0x12345678.
  - Repeat with wstrb = 0x3 -> bypass build data_o = 0x00005678.
- Reset mid-read (OUT_REG_p = 1): read issued, rstn_i pulsed low before the result emerges -> data_o = 0 and rvalid_o = 0 immediately; no pulse after release. Write attempted during reset -> a later read shows the word unchanged.
- write_i = 1 with wstrb = 0 @0x10 holding 0xCAFEF00D -> a later read returns 0xCAFEF00D.
